// File: rtl/cmp_pkg.sv
// Shared types and default widths for the comparator stream stage.
package cmp_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_READY = 2'd1,
    S_CMP   = 2'd2
  } cmp_state_t;

  localparam int CMP_WIDTH = 8;
  localparam int CMP_CNT_W = 4;

endpackage

// File: rtl/cmp_max_tracker_if.sv
// Sample stream and result bus of cmp_max_tracker.
interface cmp_max_tracker_if #(
  parameter int WIDTH = cmp_pkg::CMP_WIDTH,
  parameter int CNT_W = cmp_pkg::CMP_CNT_W
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] max_out;
  logic             max_valid;
  logic             new_max;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] tie_cnt;

  modport master (
    output in_valid, in_data,
    input  in_ready, max_out, max_valid, new_max, sample_cnt, tie_cnt
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, max_out, max_valid, new_max, sample_cnt, tie_cnt
  );

endinterface

// File: rtl/cmp_mag_unsigned.sv
// Combinational unsigned magnitude comparator: eq when a==b, gt when a>b.
module cmp_mag_unsigned #(
  parameter int WIDTH = cmp_pkg::CMP_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt
);

  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/cmp_max_tracker.sv
// Running-maximum tracker over a valid/ready sample stream.
// Optional tie counter enabled by defining CMP_MAX_TRACKER_TIE_CNT_EN.
module cmp_max_tracker
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH,
  parameter int CNT_W = CMP_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  cmp_max_tracker_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  cmp_state_t       state_r;
  cmp_state_t       next_state_s;
  logic [WIDTH-1:0] max_r;
  logic [WIDTH-1:0] samp_r;
  logic             max_valid_r;
  logic             new_max_r;
  logic [CNT_W-1:0] sample_cnt_r;
  logic             in_ready_s;
  logic             load_first_s;
  logic             load_samp_s;
  logic             upd_max_s;
  logic             eq_s;
  logic             gt_s;

  cmp_mag_unsigned #(.WIDTH(WIDTH)) u_cmp (
    .a  (samp_r),
    .b  (max_r),
    .eq (eq_s),
    .gt (gt_s)
  );

  // Next-state and datapath strobes; rst/clear override everything.
  always_comb begin
    next_state_s = state_r;
    in_ready_s   = 1'b0;
    load_first_s = 1'b0;
    load_samp_s  = 1'b0;
    upd_max_s    = 1'b0;
    if (rst || clear) begin
      next_state_s = S_EMPTY;
    end else begin
      case (state_r)
        S_EMPTY: begin
          in_ready_s = 1'b1;
          if (bus.in_valid) begin
            load_first_s = 1'b1;
            next_state_s = S_READY;
          end else begin
            next_state_s = S_EMPTY;
          end
        end
        S_READY: begin
          in_ready_s = 1'b1;
          if (bus.in_valid) begin
            load_samp_s  = 1'b1;
            next_state_s = S_CMP;
          end else begin
            next_state_s = S_READY;
          end
        end
        S_CMP: begin
          // a tie must never look like a new maximum
          upd_max_s    = gt_s & ~eq_s;
          next_state_s = S_READY;
        end
        default: begin
          next_state_s = S_EMPTY;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_r <= S_EMPTY;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Held maximum, pending sample, event pulse and saturating sample count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      max_r        <= {WIDTH{1'b0}};
      samp_r       <= {WIDTH{1'b0}};
      max_valid_r  <= 1'b0;
      new_max_r    <= 1'b0;
      sample_cnt_r <= {CNT_W{1'b0}};
    end else begin
      new_max_r <= load_first_s | upd_max_s;
      if (load_first_s) begin
        max_r       <= bus.in_data;
        max_valid_r <= 1'b1;
      end else if (upd_max_s) begin
        max_r <= samp_r;
      end
      if (load_samp_s) begin
        samp_r <= bus.in_data;
      end
      if ((load_first_s | load_samp_s) && (sample_cnt_r != CNT_MAX)) begin
        sample_cnt_r <= sample_cnt_r + CNT_ONE;
      end
    end
  end

`ifdef CMP_MAX_TRACKER_TIE_CNT_EN
  logic             tie_s;
  logic [CNT_W-1:0] tie_cnt_r;

  assign tie_s = (state_r == S_CMP) && eq_s && !rst && !clear;

  // Saturating count of samples equal to the held maximum.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tie_cnt_r <= {CNT_W{1'b0}};
    end else if (tie_s && (tie_cnt_r != CNT_MAX)) begin
      tie_cnt_r <= tie_cnt_r + CNT_ONE;
    end
  end

  assign bus.tie_cnt = tie_cnt_r;
`else
  assign bus.tie_cnt = {CNT_W{1'b0}};
`endif

  assign bus.in_ready   = in_ready_s;
  assign bus.max_out    = max_r;
  assign bus.max_valid  = max_valid_r;
  assign bus.new_max    = new_max_r;
  assign bus.sample_cnt = sample_cnt_r;

endmodule

// File: tb/tb_cmp_max_tracker.sv
// Directed self-checking bench for cmp_max_tracker (WIDTH=8, CNT_W=4).
module tb_cmp_max_tracker;

`ifdef CMP_MAX_TRACKER_TIE_CNT_EN
  localparam logic [3:0] TIE_EXP = 4'd2;
`else
  localparam logic [3:0] TIE_EXP = 4'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  int   n_tests = 0;
  int   n_fails = 0;

  cmp_max_tracker_if #(.WIDTH(8), .CNT_W(4)) bus ();

  cmp_max_tracker #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    clear = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 8) begin
      tick();
      guard++;
    end
    n_tests++;
    if (guard >= 8) begin
      n_fails++;
      $display("FAIL send_ready_timeout: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    tick();
    n_tests++;
    if (bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL reset_ready_low: got %b required 0", bus.in_ready); end
    do_reset();
    n_tests++;
    if ({bus.max_out, bus.max_valid, bus.new_max, bus.sample_cnt, bus.tie_cnt} !== 19'h0) begin
      n_fails++;
      $display("FAIL reset_values: max=%h mv=%b nm=%b sc=%0d tc=%0d required all 0",
               bus.max_out, bus.max_valid, bus.new_max, bus.sample_cnt, bus.tie_cnt);
    end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_ready_high: got %b required 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    send(8'h10);
    n_tests++;
    if (bus.max_out !== 8'h10 || bus.max_valid !== 1'b1 || bus.new_max !== 1'b1) begin
      n_fails++;
      $display("FAIL basic_first: max=%h mv=%b nm=%b required 10 1 1", bus.max_out, bus.max_valid, bus.new_max);
    end
    send(8'h05);
    tick();
    n_tests++;
    if (bus.max_out !== 8'h10 || bus.new_max !== 1'b0) begin
      n_fails++;
      $display("FAIL basic_lower: max=%h nm=%b required 10 0", bus.max_out, bus.new_max);
    end
    send(8'h40);
    tick();
    n_tests++;
    if (bus.max_out !== 8'h40 || bus.new_max !== 1'b1 || bus.sample_cnt !== 4'd3) begin
      n_fails++;
      $display("FAIL basic_higher: max=%h nm=%b sc=%0d required 40 1 3", bus.max_out, bus.new_max, bus.sample_cnt);
    end
    tick();
    n_tests++;
    if (bus.new_max !== 1'b0) begin n_fails++; $display("FAIL basic_pulse_len: new_max=%b required 0", bus.new_max); end
  endtask

  task automatic test_ties();
    int pulses = 0;
    do_reset();
    send(8'h7F);
    if (bus.new_max === 1'b1) pulses++;
    send(8'h7F);
    if (bus.new_max === 1'b1) pulses++;
    tick();
    if (bus.new_max === 1'b1) pulses++;
    send(8'h7F);
    if (bus.new_max === 1'b1) pulses++;
    tick();
    if (bus.new_max === 1'b1) pulses++;
    n_tests++;
    if (pulses != 1) begin n_fails++; $display("FAIL ties_pulses: got %0d required 1", pulses); end
    n_tests++;
    if (bus.max_out !== 8'h7F || bus.tie_cnt !== TIE_EXP) begin
      n_fails++;
      $display("FAIL ties_result: max=%h tc=%0d required 7f %0d", bus.max_out, bus.tie_cnt, TIE_EXP);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    send(8'h00);
    n_tests++;
    if (bus.max_out !== 8'h00 || bus.max_valid !== 1'b1 || bus.new_max !== 1'b1) begin
      n_fails++;
      $display("FAIL bound_zero: max=%h mv=%b nm=%b required 00 1 1", bus.max_out, bus.max_valid, bus.new_max);
    end
    send(8'hFF);
    tick();
    n_tests++;
    if (bus.max_out !== 8'hFF || bus.new_max !== 1'b1) begin
      n_fails++;
      $display("FAIL bound_ff: max=%h nm=%b required ff 1", bus.max_out, bus.new_max);
    end
    send(8'h00);
    tick();
    n_tests++;
    if (bus.max_out !== 8'hFF || bus.new_max !== 1'b0) begin
      n_fails++;
      $display("FAIL bound_zero_after_ff: max=%h nm=%b required ff 0", bus.max_out, bus.new_max);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] pattern;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    pattern[4] = bus.in_ready;
    for (int i = 3; i >= 0; i--) begin
      tick();
      pattern[i] = bus.in_ready;
    end
    bus.in_valid = 1'b0;
    n_tests++;
    if (pattern !== 5'b11010) begin n_fails++; $display("FAIL b2b_ready_pattern: got %b required 11010", pattern); end
    n_tests++;
    if (bus.sample_cnt !== 4'd3) begin n_fails++; $display("FAIL b2b_accepts: got %0d required 3", bus.sample_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(8'(i));
      if (i == 14) begin
        n_tests++;
        if (bus.sample_cnt !== 4'd15) begin n_fails++; $display("FAIL sat_at_15: got %0d required 15", bus.sample_cnt); end
      end
    end
    tick();
    n_tests++;
    if (bus.sample_cnt !== 4'd15) begin n_fails++; $display("FAIL sat_hold: got %0d required 15", bus.sample_cnt); end
    n_tests++;
    if (bus.max_out !== 8'h10) begin n_fails++; $display("FAIL sat_max: got %h required 10", bus.max_out); end
  endtask

  task automatic test_clear_in_cmp();
    do_reset();
    send(8'h20);
    send(8'hAA);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    n_tests++;
    if ({bus.max_out, bus.max_valid, bus.new_max, bus.sample_cnt, bus.tie_cnt} !== 19'h0) begin
      n_fails++;
      $display("FAIL clear_cmp_values: max=%h mv=%b nm=%b sc=%0d tc=%0d required all 0",
               bus.max_out, bus.max_valid, bus.new_max, bus.sample_cnt, bus.tie_cnt);
    end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL clear_cmp_ready: got %b required 1", bus.in_ready); end
    send(8'h05);
    n_tests++;
    if (bus.max_out !== 8'h05 || bus.new_max !== 1'b1 || bus.sample_cnt !== 4'd1) begin
      n_fails++;
      $display("FAIL clear_cmp_empty: max=%h nm=%b sc=%0d required 05 1 1", bus.max_out, bus.new_max, bus.sample_cnt);
    end
  endtask

  task automatic test_clear_with_valid();
    do_reset();
    send(8'h30);
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL clear_ready_forced: got %b required 0", bus.in_ready); end
    tick();
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.sample_cnt !== 4'd0 || bus.max_valid !== 1'b0 || bus.max_out !== 8'h00) begin
      n_fails++;
      $display("FAIL clear_valid_ignored: sc=%0d mv=%b max=%h required 0 0 00", bus.sample_cnt, bus.max_valid, bus.max_out);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_basic();
    test_ties();
    test_boundary();
    test_back_to_back();
    test_saturate();
    test_clear_in_cmp();
    test_clear_with_valid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
